// File: rtl/multi_channel_display_sequencer.sv
// -----------------------------------------------------------------------------
// multi_channel_display_sequencer
//
// Purpose:
//   Steps through NUM_CH debug channels, each DATA_W bits wide, and shows the
//   selected channel in hex on a 4-digit multiplexed 7-segment display.
//   - Auto mode advances the channel every DWELL_CYCLES clocks.
//   - Manual mode advances on each rising edge of the (already debounced)
//     step input.
//   - Hold freezes both the channel index and the displayed snapshot.
//   One dwell counter serves all modes. A single refresh counter drives the
//   digit multiplexing.
//
// Ports:
//   clock_100Mhz    in   1              system clock
//   reset           in   1              synchronous, active-high
//   ch_data         in   NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
//   auto_mode       in   1              1 = auto advance, 0 = manual step
//   step            in   1              debounced level, rising edge steps
//   hold            in   1              1 = freeze snapshot and channel index
//   Anode_Activate  out  4              digit enables, active-low, bit0 = right
//   LED_out         out  7              segments a..g on [6:0], active-low
//   displayed       out  DATA_W         snapshot currently shown
//   ch_index        out  CH_W           channel currently selected
// -----------------------------------------------------------------------------
module multi_channel_display_sequencer #(
    parameter int NUM_CH         = 12,
    parameter int DATA_W         = 8,
    parameter int DWELL_CYCLES   = 100_000_000,
    parameter int REFRESH_CYCLES = 100_000,
    parameter int BLANK_LZ       = 0,
    localparam int CH_W          = $clog2(NUM_CH)
) (
    input  logic                     clock_100Mhz,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     auto_mode,
    input  logic                     step,
    input  logic                     hold,
    output logic [3:0]               Anode_Activate,
    output logic [6:0]               LED_out,
    output logic [DATA_W-1:0]        displayed,
    output logic [CH_W-1:0]          ch_index
);

    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam int RF_W = $clog2(REFRESH_CYCLES);

    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [RF_W-1:0] REFR_LAST  = RF_W'(REFRESH_CYCLES - 1);

    // Operating mode, decoded each cycle from the mode inputs.
    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_HOLD   = 2'd2
    } mode_e;

    // Active-low hex segment pattern (a..g on bits 6..0).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // ---------------- channel / dwell state ----------------
    logic [CH_W-1:0]   ch_index_r;
    logic [DATA_W-1:0] displayed_r;
    logic [DW_W-1:0]   dwell_cnt_r;
    logic              step_prev_r;
    logic              auto_prev_r;

    mode_e             mode_s;
    logic              step_rise_s;
    logic              auto_change_s;
    logic              advance_s;
    logic [DW_W-1:0]   dwell_next_s;
    logic [CH_W-1:0]   next_index_s;
    logic [DATA_W-1:0] ch_slice_s;

    // ---------------- refresh / digit state ----------------
    logic [RF_W-1:0]   refresh_cnt_r;
    logic [1:0]        slot_r;
    logic [3:0]        anode_r;
    logic [6:0]        led_r;

    logic              refresh_tick_s;
    logic [15:0]       disp16_s;
    logic [3:0]        nibble_s;
    logic              blank_s;
    logic [3:0]        anode_next_s;
    logic [6:0]        led_next_s;

    // Mode decode, edge detection and the channel-advance decision.
    always_comb begin
        mode_s        = MODE_MANUAL;
        advance_s     = 1'b0;
        dwell_next_s  = dwell_cnt_r;
        step_rise_s   = step & ~step_prev_r;
        auto_change_s = auto_mode ^ auto_prev_r;
        next_index_s  = (ch_index_r == LAST_CH) ? {CH_W{1'b0}} : ch_index_r + CH_W'(1);

        // hold outranks both auto and manual operation
        if (hold) begin
            mode_s = MODE_HOLD;
        end else if (auto_mode) begin
            mode_s = MODE_AUTO;
        end else begin
            mode_s = MODE_MANUAL;
        end

        case (mode_s)
            MODE_AUTO: begin
                if (dwell_cnt_r == DWELL_LAST) begin
                    advance_s    = 1'b1;
                    dwell_next_s = {DW_W{1'b0}};
                end else begin
                    advance_s    = 1'b0;
                    dwell_next_s = dwell_cnt_r + DW_W'(1);
                end
            end
            MODE_MANUAL: begin
                advance_s    = step_rise_s;
                dwell_next_s = {DW_W{1'b0}};
            end
            MODE_HOLD: begin
                // step edges seen here are dropped: step_prev_r still tracks step
                advance_s    = 1'b0;
                dwell_next_s = dwell_cnt_r;
            end
            default: begin
                advance_s    = 1'b0;
                dwell_next_s = {DW_W{1'b0}};
            end
        endcase

        // a mode toggle always restarts the dwell period from zero
        if (auto_change_s) begin
            dwell_next_s = {DW_W{1'b0}};
        end else begin
            dwell_next_s = dwell_next_s;
        end
    end

    // Slice of the currently registered channel; snapshot lags index by a clock.
    assign ch_slice_s = ch_data[int'(ch_index_r) * DATA_W +: DATA_W];

    // Channel index, snapshot, dwell counter and input history registers.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            ch_index_r  <= {CH_W{1'b0}};
            displayed_r <= {DATA_W{1'b0}};
            dwell_cnt_r <= {DW_W{1'b0}};
            step_prev_r <= 1'b0;
            // seed with the live level so leaving reset is not seen as a mode toggle
            auto_prev_r <= auto_mode;
        end else begin
            step_prev_r <= step;
            auto_prev_r <= auto_mode;
            dwell_cnt_r <= dwell_next_s;
            if (advance_s) begin
                ch_index_r <= next_index_s;
            end
            if (mode_s != MODE_HOLD) begin
                displayed_r <= ch_slice_s;
            end
        end
    end

    // Digit content for the current slot, including leading-zero blanking.
    always_comb begin
        disp16_s       = 16'(displayed_r);
        refresh_tick_s = (refresh_cnt_r == REFR_LAST);
        anode_next_s   = ~(4'b0001 << slot_r);
        nibble_s       = 4'h0;
        blank_s        = 1'b0;

        // a digit is blank only if it and every digit above it are zero
        case (slot_r)
            2'd0: begin
                nibble_s = disp16_s[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                nibble_s = disp16_s[7:4];
                blank_s  = (disp16_s[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s = disp16_s[11:8];
                blank_s  = (disp16_s[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s = disp16_s[15:12];
                blank_s  = (disp16_s[15:12] == 4'h0);
            end
            default: begin
                nibble_s = 4'h0;
                blank_s  = 1'b0;
            end
        endcase

        if ((BLANK_LZ != 0) && blank_s) begin
            led_next_s = 7'h7F;
        end else begin
            led_next_s = hex_to_seg(nibble_s);
        end
    end

    // Refresh counter, digit slot and the registered display drive.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            refresh_cnt_r <= {RF_W{1'b0}};
            slot_r        <= 2'd0;
            anode_r       <= 4'b1110;
            led_r         <= 7'h01;
        end else begin
            if (refresh_tick_s) begin
                refresh_cnt_r <= {RF_W{1'b0}};
                slot_r        <= slot_r + 2'd1;
            end else begin
                refresh_cnt_r <= refresh_cnt_r + RF_W'(1);
            end
            anode_r <= anode_next_s;
            led_r   <= led_next_s;
        end
    end

    assign Anode_Activate = anode_r;
    assign LED_out        = led_r;
    assign displayed      = displayed_r;
    assign ch_index       = ch_index_r;

endmodule

// File: tb/tb_multi_channel_display_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_display_sequencer
//
// Directed bench for the display sequencer: 3 channels of 8 bits, a dwell of
// 10 clocks, a refresh slot of 4 clocks and leading-zero blanking enabled.
// Expected values are hand-computed cycle by cycle from a reset edge.
// -----------------------------------------------------------------------------
module tb_multi_channel_display_sequencer;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                     clk;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     auto_mode;
    logic                     step;
    logic                     hold;
    logic [3:0]               anode;
    logic [6:0]               led;
    logic [DATA_W-1:0]        displayed;
    logic [CH_W-1:0]          ch_index;

    int total_cnt;
    int bad_cnt;

    multi_channel_display_sequencer #(
        .NUM_CH        (NUM_CH),
        .DATA_W        (DATA_W),
        .DWELL_CYCLES  (10),
        .REFRESH_CYCLES(4),
        .BLANK_LZ      (1)
    ) dut (
        .clock_100Mhz  (clk),
        .reset         (reset),
        .ch_data       (ch_data),
        .auto_mode     (auto_mode),
        .step          (step),
        .hold          (hold),
        .Anode_Activate(anode),
        .LED_out       (led),
        .displayed     (displayed),
        .ch_index      (ch_index)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset     = 1'b1;
        auto_mode = 1'b1;
        step      = 1'b0;
        hold      = 1'b0;
        ch_data   = {8'h33, 8'h22, 8'h11};

        // T1: reset values
        tick();
        check_eq("t1_index", 16'(ch_index), 16'h0000);
        check_eq("t1_anode", 16'(anode), 16'h000E);
        check_eq("t1_led", 16'(led), 16'h0001);
        check_eq("t1_disp", 16'(displayed), 16'h0000);
        reset = 1'b0;

        // T2: auto wrap, index every 10 clocks, snapshot one clock later
        tick();
        check_eq("t2_disp_e1", 16'(displayed), 16'h0011);
        tick_n(8);
        check_eq("t2_idx_e9", 16'(ch_index), 16'h0000);
        tick();
        check_eq("t2_idx_e10", 16'(ch_index), 16'h0001);
        check_eq("t2_disp_e10", 16'(displayed), 16'h0011);
        tick();
        check_eq("t2_disp_e11", 16'(displayed), 16'h0022);
        tick_n(9);
        check_eq("t2_idx_e20", 16'(ch_index), 16'h0002);
        tick();
        check_eq("t2_disp_e21", 16'(displayed), 16'h0033);
        tick_n(9);
        check_eq("t2_idx_wrap", 16'(ch_index), 16'h0000);
        tick();
        check_eq("t2_disp_e31", 16'(displayed), 16'h0011);

        // T3: manual stepping, one advance per rising edge
        auto_mode = 1'b0;
        do_reset();
        step = 1'b1;
        tick_n(5);
        step = 1'b0;
        tick_n(2);
        check_eq("t3_long_step", 16'(ch_index), 16'h0001);
        step = 1'b1; tick(); step = 1'b0; tick();
        check_eq("t3_pulse1", 16'(ch_index), 16'h0002);
        step = 1'b1; tick(); step = 1'b0; tick();
        check_eq("t3_pulse2_wrap", 16'(ch_index), 16'h0000);

        // T4: hold across a dwell terminal count and a step edge
        auto_mode = 1'b1;
        ch_data   = {8'h33, 8'h22, 8'h11};
        do_reset();
        tick_n(9);
        check_eq("t4_pre_idx", 16'(ch_index), 16'h0000);
        hold    = 1'b1;
        ch_data = {8'h33, 8'h22, 8'h99};
        tick();
        check_eq("t4_hold_idx", 16'(ch_index), 16'h0000);
        check_eq("t4_hold_disp", 16'(displayed), 16'h0011);
        step = 1'b1; tick(); step = 1'b0; tick();
        check_eq("t4_hold_idx2", 16'(ch_index), 16'h0000);
        check_eq("t4_hold_disp2", 16'(displayed), 16'h0011);
        hold = 1'b0;
        tick();
        check_eq("t4_resume_idx", 16'(ch_index), 16'h0001);
        check_eq("t4_resume_disp", 16'(displayed), 16'h0099);
        tick();
        check_eq("t4_resume_disp2", 16'(displayed), 16'h0022);

        // step edge arriving during hold is dropped, not queued
        auto_mode = 1'b0;
        hold      = 1'b1;
        step      = 1'b1;
        tick_n(2);
        hold = 1'b0;
        tick();
        check_eq("t4_drop_edge", 16'(ch_index), 16'h0001);
        step = 1'b0; tick(); step = 1'b1; tick();
        check_eq("t4_after_drop", 16'(ch_index), 16'h0002);
        step = 1'b0;

        // T5: refresh slots with displayed = A5 and leading-zero blanking
        auto_mode = 1'b0;
        ch_data   = {8'h33, 8'h22, 8'hA5};
        do_reset();
        tick();
        check_eq("t5_disp", 16'(displayed), 16'h00A5);
        tick();
        check_eq("t5_s0_led", 16'(led), 16'h0024);
        check_eq("t5_s0_an", 16'(anode), 16'h000E);
        tick_n(2);
        check_eq("t5_s0_an_late", 16'(anode), 16'h000E);
        tick();
        check_eq("t5_s1_led", 16'(led), 16'h0008);
        check_eq("t5_s1_an", 16'(anode), 16'h000D);
        tick_n(4);
        check_eq("t5_s2_led", 16'(led), 16'h007F);
        check_eq("t5_s2_an", 16'(anode), 16'h000B);
        tick_n(4);
        check_eq("t5_s3_led", 16'(led), 16'h007F);
        check_eq("t5_s3_an", 16'(anode), 16'h0007);
        tick_n(4);
        check_eq("t5_wrap_led", 16'(led), 16'h0024);
        check_eq("t5_wrap_an", 16'(anode), 16'h000E);

        // T6: reset mid-dwell at index 2, then auto resumes from 0
        auto_mode = 1'b1;
        ch_data   = {8'h33, 8'h22, 8'h11};
        do_reset();
        tick_n(23);
        check_eq("t6_pre_idx", 16'(ch_index), 16'h0002);
        reset = 1'b1;
        tick();
        check_eq("t6_index", 16'(ch_index), 16'h0000);
        check_eq("t6_anode", 16'(anode), 16'h000E);
        check_eq("t6_led", 16'(led), 16'h0001);
        check_eq("t6_disp", 16'(displayed), 16'h0000);
        reset = 1'b0;
        tick();
        check_eq("t6_disp_e1", 16'(displayed), 16'h0011);
        tick_n(8);
        check_eq("t6_idx_e9", 16'(ch_index), 16'h0000);
        tick();
        check_eq("t6_idx_e10", 16'(ch_index), 16'h0001);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
